// File: rtl/motor_ramp_ctrl.sv
// Speed/direction sequencer for the PWM motor stage: slews duty toward the target at a
// fixed rate, forces zero duty plus a dead time before any reversal, and handles estop.
module motor_ramp_ctrl #(
  parameter int WIDTH    = 12,
  parameter int STEP_DIV = 5000,
  parameter int STEP     = 16,
  parameter int DEAD_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             estop,
  input  logic [WIDTH-1:0] target,
  input  logic             target_dir,
  output logic [WIDTH-1:0] duty,
  output logic             dir,
  output logic             at_speed,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_HOLD  = 3'd2,
    S_BRAKE = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0]  DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [WIDTH:0] STEP_X    = (WIDTH + 1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;

  logic             tick;
  logic             mismatch;
  logic [WIDTH-1:0] eff;

  // One extra bit of headroom so the sum/limit can never wrap.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] goal);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + STEP_X;
    return (sum >= {1'b0, goal}) ? goal : sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] goal);
    logic [WIDTH:0] lim;
    lim = {1'b0, goal} + STEP_X;
    return ({1'b0, cur} <= lim) ? goal : (cur - STEP_X[WIDTH-1:0]);
  endfunction

  assign tick     = (pre_q == PRE_LAST);
  assign pre_d    = tick ? '0 : pre_q + 1'b1;
  assign eff      = enable ? target : '0;
  assign mismatch = (target_dir != dir_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dcnt_d  = dcnt_q;
    if (estop) begin
      duty_d  = '0;
      state_d = S_DEAD;
      dcnt_d  = DEAD_LAST;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mismatch) begin
            state_d = S_DEAD;
            dcnt_d  = DEAD_LAST;
          end else if (eff != '0) begin
            state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          if (mismatch) begin
            state_d = S_BRAKE;
          end else if (duty_q == eff) begin
            state_d = (eff == '0) ? S_IDLE : S_HOLD;
          end else if (tick) begin
            duty_d = (duty_q < eff) ? step_up(duty_q, eff) : step_down(duty_q, eff);
          end
        end
        S_HOLD: begin
          if (mismatch) begin
            state_d = S_BRAKE;
          end else if (eff != duty_q) begin
            state_d = S_RAMP;
          end
        end
        S_BRAKE: begin
          if (duty_q == '0) begin
            state_d = S_DEAD;
            dcnt_d  = DEAD_LAST;
          end else if (tick) begin
            duty_d = step_down(duty_q, '0);
          end
        end
        S_DEAD: begin
          duty_d = '0;
          // Direction may only change here, where duty is already zero.
          if (dcnt_q == '0) begin
            dir_d   = target_dir;
            state_d = S_IDLE;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      pre_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign duty     = duty_q;
  assign dir      = dir_q;
  assign state    = state_q;
  assign at_speed = (state_q == S_HOLD);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with small parameters; also watches slew rate and
// direction changes on every sampled cycle.
module tb_motor_ramp_ctrl;
  localparam int W  = 12;
  localparam int SD = 4;
  localparam int ST = 16;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         reset, enable, estop, target_dir;
  logic [W-1:0] target, duty;
  logic         dir, at_speed, busy;
  logic [2:0]   state;

  int           total = 0;
  int           bad   = 0;
  logic         est_q = 1'b0;
  logic [W-1:0] prev_duty;
  logic         prev_dir;
  int           seq [8];
  int           g, n;

  always #5 clk = ~clk;
  always @(posedge clk) est_q <= estop;

  motor_ramp_ctrl #(.WIDTH(W), .STEP_DIV(SD), .STEP(ST), .DEAD_CYC(DC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .estop(estop), .target(target),
    .target_dir(target_dir), .duty(duty), .dir(dir), .at_speed(at_speed),
    .busy(busy), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int d;
    @(negedge clk);
    if (!reset) begin
      d = int'(duty) - int'(prev_duty);
      if (d < 0) d = -d;
      if (duty !== prev_duty && !est_q) chk("slew_limit", (d <= ST), 1);
      if (dir !== prev_dir) chk("dir_toggle_at_zero", (duty == 0 && prev_duty == 0), 1);
    end
    prev_duty = duty;
    prev_dir  = dir;
  endtask

  task automatic wait_chg(output int gap);
    logic [W-1:0] last;
    last = duty;
    gap  = 0;
    do begin
      step();
      gap++;
    end while (duty == last && gap < 64);
    if (duty == last) chk("duty_change_timeout", gap, 0);
  endtask

  task automatic run_seq(input string tag, input int cnt);
    int gp;
    for (int i = 0; i < cnt; i++) begin
      wait_chg(gp);
      chk({tag, "_duty"}, duty, seq[i]);
      if (i > 0) chk({tag, "_tick_gap"}, gp, SD);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_at_speed"}, at_speed, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; estop = 1'b0; target = '0; target_dir = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1: asynchronous reset mid-run
    enable = 1'b1; target = 12'd100;
    wait_chg(g);
    chk("t1_first_step", duty, 16);
    step(); step();
    #3 reset = 1'b1;
    #1 check_reset_outputs("t1_async");
    step();
    enable = 1'b0; target = '0; reset = 1'b0;
    step();

    // 2: ramp up to 100, then hold
    enable = 1'b1; target = 12'd100; target_dir = 1'b0;
    seq = '{16, 32, 48, 64, 80, 96, 100, 0};
    run_seq("t2_up", 7);
    step();
    chk("t2_state_hold", state, 2);
    chk("t2_at_speed", at_speed, 1);
    chk("t2_busy", busy, 1);

    // 3: reversal: brake, dead time, new direction, ramp back up
    target_dir = 1'b1;
    step();
    chk("t3_state_brake", state, 3);
    seq = '{84, 68, 52, 36, 20, 4, 0, 0};
    run_seq("t3_brake", 7);
    chk("t3_brake_at_zero", state, 3);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (dir == 1'b1) break;
      if (state == 3'd4 && duty == 0) n++;
    end
    chk("t3_dead_cycles", n, DC);
    chk("t3_dir_new", dir, 1);
    chk("t3_idle_after_dead", state, 0);
    seq = '{16, 32, 48, 64, 80, 96, 100, 0};
    run_seq("t3_reramp", 7);
    step();
    chk("t3_hold_again", state, 2);

    // 4: estop during ramp
    estop = 1'b1;
    step();
    chk("t4_pulse_duty", duty, 0);
    chk("t4_pulse_state", state, 4);
    estop = 1'b0;
    for (int i = 0; i < 100 && duty != 48; i++) step();
    chk("t4_reach48", duty, 48);
    chk("t4_ramp_state", state, 1);
    estop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_estop_duty", duty, 0);
      chk("t4_estop_state", state, 4);
    end
    estop = 1'b0;
    n = 0;
    while (state == 3'd4 && n < 40) begin
      step();
      n++;
    end
    chk("t4_dead_after_release", n, DC);
    chk("t4_idle", state, 0);
    chk("t4_dir_kept", dir, 1);
    step();
    chk("t4_ramp_again", state, 1);
    wait_chg(g);
    chk("t4_ramp_from_zero", duty, 16);

    // 5: lower target, then controlled stop
    for (int i = 0; i < 10 && duty != 100; i++) wait_chg(g);
    chk("t5_at100", duty, 100);
    step();
    chk("t5_hold100", state, 2);
    target = 12'd40;
    seq = '{84, 68, 52, 40, 0, 0, 0, 0};
    run_seq("t5_down40", 4);
    step();
    chk("t5_hold40", state, 2);
    enable = 1'b0;
    seq = '{24, 8, 0, 0, 0, 0, 0, 0};
    run_seq("t5_stop", 3);
    step();
    chk("t5_idle", state, 0);
    chk("t5_not_busy", busy, 0);

    // 6: asynchronous reset mid-brake
    enable = 1'b1; target = 12'd100;
    seq = '{16, 32, 48, 64, 80, 96, 100, 0};
    run_seq("t6_up", 7);
    step();
    chk("t6_hold", state, 2);
    target_dir = 1'b0;
    seq = '{84, 68, 52, 0, 0, 0, 0, 0};
    run_seq("t6_brake", 3);
    chk("t6_in_brake", state, 3);
    #3 reset = 1'b1;
    #1 check_reset_outputs("t6_async");
    step();
    reset = 1'b0;
    wait_chg(g);
    chk("t6_restart", duty, 16);
    chk("t6_restart_dir", dir, 0);
    for (int i = 0; i < 10 && duty != 100; i++) wait_chg(g);
    chk("t6_at100", duty, 100);
    step();
    chk("t6_hold_final", state, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
